// File: rtl/sm_hex_display.sv
// Eight-digit multiplexed hex display driver for a common-anode 7-segment bank.
// Double-buffered value, guard-band between digits, optional leading-zero blanking.
module sm_hex_display #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int GUARD_CYCLES = 500,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        load,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        frame_done
);

    typedef enum logic {GUARD = 1'b0, ON = 1'b1} state_t;

    localparam int CW = 21;
    localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DIGIT_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [31:0]   pending, shown;
    logic          pend_flag;
    logic [7:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic [31:0]   upper;
    logic          blank;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        unique case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
        endcase
        return g;
    endfunction

    // State register: phase, phase counter and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= GUARD;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state: GUARD -> ON after GUARD_CYCLES, ON -> GUARD of next digit after DIGIT_CYCLES
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        unique case (state)
            GUARD: begin
                if (cnt == G_LAST) begin
                    state_nxt = ON;
                    cnt_nxt   = '0;
                end
            end
            ON: begin
                if (cnt == D_LAST) begin
                    state_nxt = GUARD;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 3'd1;
                end
            end
        endcase
    end

    // Output decode, computed from the next state so the registered outputs track the state exactly
    always_comb begin
        frame_done = (state == ON) && (idx == 3'd7) && (cnt == D_LAST);
        upper      = shown >> {idx_nxt, 2'b00};
        blank      = BLANK_LZ && (idx_nxt != 3'd0) && (upper == 32'd0);
        an_nxt     = 8'hFF;
        seg_nxt    = 7'h7F;
        if (state_nxt == ON && !blank) begin
            an_nxt  = ~(8'b1 << idx_nxt);
            seg_nxt = glyph(shown[{idx_nxt, 2'b00} +: 4]);
        end
    end

    // Display buffers: pending captures loads, shown swaps only at a frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            shown     <= '0;
            pend_flag <= 1'b0;
        end else begin
            if (frame_done && pend_flag) begin
                shown     <= pending;
                pend_flag <= 1'b0;
            end
            if (load) begin
                pending   <= data;
                pend_flag <= 1'b1;
            end
        end
    end

    // Registered anode and segment drivers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n  <= 8'hFF;
            seg_n <= 7'h7F;
        end else begin
            an_n  <= an_nxt;
            seg_n <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_sm_hex_display.sv
// Directed bench for sm_hex_display with GUARD=2, DIGIT=4 (48-cycle frames).
// One instance blanks leading zeros, the other shows all digits.
module tb_sm_hex_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data = '0;
    logic        load = 1'b0;
    logic [7:0]  an_n1, an_n0;
    logic [6:0]  seg_n1, seg_n0;
    logic        fd1, fd0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                   7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03,
                                   7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    sm_hex_display #(.DIGIT_CYCLES(4), .GUARD_CYCLES(2), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .data(data), .load(load),
        .an_n(an_n1), .seg_n(seg_n1), .frame_done(fd1)
    );

    sm_hex_display #(.DIGIT_CYCLES(4), .GUARD_CYCLES(2), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .data(data), .load(load),
        .an_n(an_n0), .seg_n(seg_n0), .frame_done(fd0)
    );

    // Anode safety monitor: one-hot-low and a dark cycle between different digits
    logic [7:0] last1 = 8'hFF;
    logic [7:0] last0 = 8'hFF;
    always @(negedge clk) begin
        n_cmp += 2;
        if ($countones(~an_n1) > 1 || (an_n1 != 8'hFF && last1 != 8'hFF && last1 != an_n1)) begin
            n_bad++;
            $display("FAIL anode_mon1 got %h after %h", an_n1, last1);
        end
        if ($countones(~an_n0) > 1 || (an_n0 != 8'hFF && last0 != 8'hFF && last0 != an_n0)) begin
            n_bad++;
            $display("FAIL anode_mon0 got %h after %h", an_n0, last0);
        end
        last1 <= an_n1;
        last0 <= an_n0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    // Runs one 48-cycle frame, optionally strobing load before edges la1/la2
    task automatic run_frame(input bit which, input logic [31:0] sh,
                             input int la1, input logic [31:0] d1,
                             input int la2, input logic [31:0] d2,
                             input string tag);
        for (int i = 1; i <= 48; i++) begin
            bit         lit, blz, blank;
            int         d;
            logic [7:0] ea, oa;
            logic [6:0] os;
            logic       of;
            if (i == la1) begin
                load = 1'b1;
                data = d1;
            end else if (i == la2) begin
                load = 1'b1;
                data = d2;
            end
            step();
            load = 1'b0;
            blz = which;
            lit = (i >= 2) && (((i - 2) % 6) < 4);
            d = lit ? (i - 2) / 6 : 0;
            blank = blz && (d != 0);
            for (int k = d; k < 8; k++)
                if (sh[k*4 +: 4] != 4'h0) blank = 1'b0;
            ea = (lit && !blank) ? ~(8'h01 << d) : 8'hFF;
            oa = which ? an_n1 : an_n0;
            os = which ? seg_n1 : seg_n0;
            of = which ? fd1 : fd0;
            n_cmp++;
            if (oa !== ea) begin
                n_bad++;
                $display("FAIL %s an_n i=%0d got %h want %h", tag, i, oa, ea);
            end
            if (!lit || !blank) begin
                logic [6:0] es;
                es = lit ? glyph_tab[sh[d*4 +: 4]] : 7'h7F;
                n_cmp++;
                if (os !== es) begin
                    n_bad++;
                    $display("FAIL %s seg_n i=%0d got %h want %h", tag, i, os, es);
                end
            end
            n_cmp++;
            if (of !== (i == 47)) begin
                n_bad++;
                $display("FAIL %s frame_done i=%0d got %b want %b", tag, i, of, (i == 47));
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (an_n1 !== 8'hFF || seg_n1 !== 7'h7F || fd1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset got an=%h seg=%h fd=%b want FF 7F 0", an_n1, seg_n1, fd1);
        end
        do_reset();
    endtask

    task automatic test_idle();
        run_frame(1, 32'h0, 0, 0, 0, 0, "idle_f1");
        run_frame(1, 32'h0, 0, 0, 0, 0, "idle_f2");
    endtask

    task automatic test_load_midframe();
        run_frame(1, 32'h0, 10, 32'h0000_1A3F, 0, 0, "mid_old");
        run_frame(1, 32'h0000_1A3F, 0, 0, 0, 0, "mid_new");
    endtask

    task automatic test_back_to_back();
        run_frame(1, 32'h0000_1A3F, 5, 32'h1111_1111, 20, 32'h2222_2222, "b2b_a");
        run_frame(1, 32'h2222_2222, 10, 32'h4444_4444, 48, 32'h5555_5555, "b2b_b");
        run_frame(1, 32'h4444_4444, 0, 0, 0, 0, "b2b_c");
        run_frame(1, 32'h5555_5555, 0, 0, 0, 0, "b2b_d");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 33; i++) step();
        n_cmp++;
        if (an_n1 !== 8'hDF) begin
            n_bad++;
            $display("FAIL ar_digit5 an_n got %h want DF", an_n1);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (an_n1 !== 8'hFF || seg_n1 !== 7'h7F || fd1 !== 1'b0) begin
            n_bad++;
            $display("FAIL ar_async got an=%h seg=%h fd=%b want FF 7F 0", an_n1, seg_n1, fd1);
        end
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        run_frame(1, 32'h0, 1, 32'h0000_00C0, 0, 0, "ar_f1");
        run_frame(1, 32'h0000_00C0, 0, 0, 0, 0, "ar_f2");
    endtask

    task automatic test_no_blank();
        do_reset();
        run_frame(0, 32'h0, 1, 32'h0, 0, 0, "nb_f1");
        run_frame(0, 32'h0, 0, 0, 0, 0, "nb_f2");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_midframe();
        test_back_to_back();
        test_async_reset();
        test_no_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sm_hex_display.md
SM_HEX_DISPLAY -- requirements
Module: sm_hex_display

Interface
REQ-001 Parameter DIGIT_CYCLES, default 50000: clk cycles one digit is lit (ON phase); legal range 2..2^20.
REQ-002 Parameter GUARD_CYCLES, default 500: clk cycles all anodes are off before each digit (GUARD phase); legal range 1..2^16.
REQ-003 Parameter BLANK_LZ, default 1: 1 blanks leading zero digits, 0 shows all 8 digits.
REQ-004 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset; asynchronous and active-high.
REQ-006 Port data, input, 32: value to display as 8 hex digits; digit k shows data[4k+3:4k].
REQ-007 Port load, input, 1: single-cycle strobe; data is captured into the pending register on a cycle where load=1.
REQ-008 Port an_n, output, 8: digit anodes, active-low; at most one bit low at any time.
REQ-009 Port seg_n, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 Port frame_done, output, 1: one-cycle pulse when digit 7 finishes its ON phase.

Function
REQ-011 Internal registers: pending[31:0], shown[31:0], pend_flag, digit index idx[2:0], phase counter, state in {GUARD, ON}.
REQ-012 load=1 writes pending<=data and sets pend_flag; multiple loads within a frame keep only the last value.
REQ-013 shown SHALL update only at a frame boundary: on the cycle frame_done=1, if pend_flag=1 then shown<=pending and pend_flag<=0.
REQ-014 If load=1 coincides with frame_done=1, the boundary transfers the old pending value; the new data is written to pending, and pend_flag stays 1 for the next boundary.
REQ-015 GUARD state: an_n=8'hFF, seg_n=7'h7F; counter counts 0..GUARD_CYCLES-1, then state<=ON and counter<=0.
REQ-016 ON state: an_n has bit idx low only; seg_n drives the hex glyph of shown nibble idx; counter counts 0..DIGIT_CYCLES-1, then state<=GUARD, counter<=0, idx<=idx+1.
REQ-017 idx wraps from 7 to 0; frame_done=1 on exactly the last ON cycle of idx=7.
REQ-018 Glyphs: standard 7-segment hex 0-9, A, b, C, d, E, F; for example, 0 gives seg_n=7'h40, 8 gives 7'h00, F gives 7'h0E.
REQ-019 Leading-zero blanking (BLANK_LZ=1): digit k is blanked (an_n=8'hFF during its ON phase) if every nibble k..7 of shown is zero and k!=0; digit 0 is never blanked.
REQ-020 Blanking SHALL NOT alter the timing: a blanked digit still occupies its full GUARD and ON phases.
REQ-021 an_n and seg_n SHALL be registered outputs with no combinational path from data or load.
REQ-022 One frame lasts 8*(GUARD_CYCLES+DIGIT_CYCLES) cycles, with no other gaps.

Reset
REQ-023 Asserting rst SHALL immediately force an_n=8'hFF, seg_n=7'h7F, frame_done=0, state=GUARD, idx=0, counter=0, pending=0, shown=0, pend_flag=0.
REQ-024 Reset asserted mid-ON SHALL turn the digit off without waiting for clk; after release, operation restarts at GUARD for idx 0.
REQ-025 A load in the cycle rst deasserts SHALL be captured normally.

Verification
REQ-026 GUARD=2, DIGIT=4, reset released, no load -> frame of 48 cycles; only digit 0 lit, seg_n=7'h40; an_n=8'hFE during its ON phase; frame_done pulses every 48 cycles.
REQ-027 load data=32'h0000_1A3F mid-frame -> display unchanged until frame_done; the next frame shows digits 0-3 as F,3,A,1 (7'h0E,7'h30,7'h08,7'h79), and digits 4-7 are blanked.
REQ-028 BLANK_LZ=0 with data=32'h0000_0000 loaded -> all 8 digits show 7'h40 in turn, and an_n walks FE,FD,...,7F.
REQ-029 Two loads (32'h1111_1111, then 32'h2222_2222) in the same frame -> only 2s ever appear; a load coinciding with frame_done is displayed one frame later.
REQ-030 rst pulsed asynchronously (between clk edges) during digit 5 ON -> an_n=8'hFF before the next clk edge; after release, GUARD then digit 0 is shown with shown=0.
REQ-031 Throughout all tests, the assertion holds that an_n never has more than one zero bit and that at least one GUARD cycle separates any two distinct lit anodes.
